spi_uart_bridge: RTL and testbench

//  Parametrised SPI-slave to UART-TX bridge; successor to the single-byte spi_to_uart path.

---
 rtl/spi_uart_pkg.sv | 21 ++
 rtl/spi_uart_bridge_uart_tx.sv | 151 +++++++++++++++
 rtl/spi_uart_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_spi_uart_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_uart_pkg.sv
// Shared state encodings, status-word layout and sizing helper for the SPI-to-UART bridge.
package spi_uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t UART_IDLE   = 3'd0;
    localparam uart_state_t UART_START  = 3'd1;
    localparam uart_state_t UART_DATA   = 3'd2;
    localparam uart_state_t UART_PARITY = 3'd3;
    localparam uart_state_t UART_STOP   = 3'd4;

    // Status word flag positions, counted down from the MSB; the level field fills the rest.
    localparam int unsigned STATUS_OVF_POS  = 0;
    localparam int unsigned STATUS_FULL_POS = 1;
    localparam int unsigned STATUS_FLAGS    = 2;

    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_uart_bridge_uart_tx.sv
// UART transmitter core: baud counter, framing FSM and LSB-first shift register behind a
// valid/ready pop port. Defining SPI_UART_PARITY_EN inserts an even-parity bit before STOP.
module uart_tx_core
    import spi_uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned       BIT_W     = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              baud_done;
`ifdef SPI_UART_PARITY_EN
    logic              par_q, par_d;
`endif

    assign baud_done = (baud_q == BAUD_LAST);
    assign ready_o   = (state_q == UART_IDLE);
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
`ifdef SPI_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            UART_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (valid_i) begin
                    shift_d = data_i;
`ifdef SPI_UART_PARITY_EN
                    par_d   = ^data_i;
`endif
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            UART_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef SPI_UART_PARITY_EN
                        tx_d    = par_q;
                        state_d = UART_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef SPI_UART_PARITY_EN
            UART_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = UART_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            UART_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    busy_d  = 1'b0;
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
                state_d = UART_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SPI_UART_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: rtl/spi_uart_bridge.sv
// SPI mode-0 slave feeding a DEPTH-entry FIFO drained by a UART transmitter; MISO returns a
// status word (overflow, full, level). Frame parity is selected by SPI_UART_PARITY_EN.
module spi_uart_bridge
    import spi_uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                   system_clk,
    input  logic                   reset,
    input  logic                   sclk,
    input  logic                   cs_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   uart_tx,
    output logic                   tx_busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    localparam int unsigned LEVEL_W   = level_w(DEPTH);
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DATA_W);
    localparam int unsigned SW        = DATA_W - STATUS_FLAGS;
    localparam int unsigned LEVEL_MAX = (1 << SW) - 1;
    localparam int unsigned OVF_BIT   = DATA_W - 1 - STATUS_OVF_POS;
    localparam int unsigned FULL_BIT  = DATA_W - 1 - STATUS_FULL_POS;

    // Stage [1] is the synchronised value, stage [2] its one-cycle history for edge detect.
    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise, cs_low, mosi_s;

    always_ff @(posedge system_clk) begin
        if (reset) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_low    = ~cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] count_q, count_d;
    logic              ovf_q, ovf_d, ovf_clr;
    logic              fifo_full, fifo_empty, tx_ready, pop, push_ok, push_drop;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] status_sr_q, status_sr_d;
    logic              miso_q, miso_d;
    logic              first_q, first_d;
    logic              stat_ovf_q, stat_ovf_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] push_data_q, push_data_d;
    logic [DATA_W-1:0] status_now, status_reload;

    assign fifo_full  = (count_q == LEVEL_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & tx_ready;
    assign push_ok    = push_q & (~fifo_full | pop);
    assign push_drop  = push_q & fifo_full & ~pop;

    always_comb begin
        status_now           = '0;
        status_now[OVF_BIT]  = ovf_q;
        status_now[FULL_BIT] = fifo_full;
        if (32'(count_q) > LEVEL_MAX) begin
            status_now[SW-1:0] = '1;
        end else begin
            status_now[SW-1:0] = SW'(count_q);
        end
        // A word that just read overflow=1 clears it, so the next word must already show 0.
        status_reload          = status_now;
        status_reload[OVF_BIT] = ovf_q & ~stat_ovf_q;
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        status_sr_d = status_sr_q;
        miso_d      = miso_q;
        first_d     = first_q;
        stat_ovf_d  = stat_ovf_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        ovf_clr     = 1'b0;
        if (cs_fall) begin
            bit_cnt_d   = '0;
            status_sr_d = status_now;
            miso_d      = status_now[DATA_W-1];
            stat_ovf_d  = ovf_q;
            first_d     = 1'b0;
        end else if (cs_rise) begin
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            first_d   = 1'b0;
        end else if (cs_low) begin
            if (sclk_rise) begin
                rx_sr_d = {rx_sr_q[DATA_W-3:0], mosi_s};
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    bit_cnt_d   = '0;
                    push_d      = 1'b1;
                    push_data_d = {rx_sr_q, mosi_s};
                    ovf_clr     = stat_ovf_q;
                    status_sr_d = status_reload;
                    stat_ovf_d  = status_reload[OVF_BIT];
                    first_d     = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end else if (sclk_fall) begin
                // First falling edge of a follow-on word presents the fresh MSB unshifted.
                if (first_q) begin
                    miso_d  = status_sr_q[DATA_W-1];
                    first_d = 1'b0;
                end else begin
                    status_sr_d = status_sr_q << 1;
                    miso_d      = status_sr_q[DATA_W-2];
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + LEVEL_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - LEVEL_W'(1);
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            status_sr_q <= '0;
            miso_q      <= 1'b0;
            first_q     <= 1'b0;
            stat_ovf_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            status_sr_q <= status_sr_d;
            miso_q      <= miso_d;
            first_q     <= first_d;
            stat_ovf_q  <= stat_ovf_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge system_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

    uart_tx_core #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_i   (system_clk),
        .rst_i   (reset),
        .valid_i (~fifo_empty),
        .data_i  (mem_q[rd_ptr_q]),
        .ready_o (tx_ready),
        .tx_o    (uart_tx),
        .busy_o  (tx_busy)
    );

    assign miso       = miso_q;
    assign fifo_level = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_spi_uart_bridge.sv
// Directed-plus-random bench for spi_uart_bridge with an SPI master driver, a UART receiver
// monitor and a queue-based reference of the bytes that must appear on the line.
module tb_spi_uart_bridge;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 128;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       reset, sclk, cs_n, mosi;
    logic       miso, uart_tx, tx_busy, overflow;
    logic [2:0] fifo_level;

    always #10 clk = ~clk;

    spi_uart_bridge #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .system_clk (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    int            peak  = 0;
    bit            mon_abort = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] tx_buf [8];
    logic [DW-1:0] rx_buf [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Status as the master should read it: overflow, full, then the saturated level.
    function automatic logic [DW-1:0] exp_status(input bit ovf, input int lvl);
        logic [DW-1:0] s;
        s[DW-1]   = ovf;
        s[DW-2]   = (lvl == DEPTH);
        s[DW-3:0] = (lvl > 63) ? 6'h3f : 6'(lvl);
        return s;
    endfunction

    always @(negedge clk) begin
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end

    // UART receiver: mid-bit sampling from the falling start edge.
    always begin
        logic [DW-1:0] d;
        logic          s0, st;
`ifdef SPI_UART_PARITY_EN
        logic          par;
`endif
        @(negedge uart_tx);
        repeat (CPB / 2) @(negedge clk);
        s0 = uart_tx;
        for (int i = 0; i < DW; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = uart_tx;
        end
`ifdef SPI_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = uart_tx;
`endif
        repeat (CPB) @(negedge clk);
        st = uart_tx;
        if (!mon_abort) begin
            check("start bit", 32'(s0), 32'(0));
`ifdef SPI_UART_PARITY_EN
            check("parity bit", 32'(par), 32'(^d));
`endif
            check("stop bit", 32'(st), 32'(1));
            got_q.push_back(d);
        end
    end

    task automatic spi_xfer(input int n);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int w = 0; w < n; w++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                mosi = tx_buf[w][b];
                repeat (HALF) @(negedge clk);
                sclk = 1'b1;
                rx_buf[w] = {rx_buf[w][DW-2:0], miso};
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_partial(input int nbits, input logic [DW-1:0] val);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = DW - 1; b >= DW - nbits; b--) begin
            mosi = val[b];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 40000) begin
            @(negedge clk);
            t++;
        end
        repeat (12 * CPB) @(negedge clk);
        check({tag, " frame count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, " byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, " level idle"}, 32'(fifo_level), 32'(0));
        check({tag, " busy idle"}, 32'(tx_busy), 32'(0));
        check({tag, " line idle"}, 32'(uart_tx), 32'(1));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("reset uart_tx", 32'(uart_tx), 32'(1));
        check("reset miso", 32'(miso), 32'(0));
        check("reset level", 32'(fifo_level), 32'(0));
        check("reset busy", 32'(tx_busy), 32'(0));
        check("reset overflow", 32'(overflow), 32'(0));

        tx_buf[0] = 8'hA5;
        spi_xfer(1);
        exp_q.push_back(8'hA5);
        check("a5 status", 32'(rx_buf[0]), 32'(exp_status(0, 0)));
        check("a5 busy", 32'(tx_busy), 32'(1));
        drain("a5");

        peak = 0;
        tx_buf[0] = 8'h00;
        tx_buf[1] = 8'h03;
        tx_buf[2] = 8'h06;
        spi_xfer(3);
        for (int i = 0; i < 3; i++) exp_q.push_back(tx_buf[i]);
        check("b2b status", 32'(rx_buf[0]), 32'(exp_status(0, 0)));
        drain("b2b");
        // First word goes straight to the transmitter, the other two wait in the FIFO.
        check("b2b peak level", 32'(peak), 32'(2));

        for (int i = 0; i < 6; i++) tx_buf[i] = 8'($urandom);
        spi_xfer(6);
        for (int i = 0; i <= DEPTH; i++) exp_q.push_back(tx_buf[i]);
        check("burst status", 32'(rx_buf[0]), 32'(exp_status(0, 0)));
        check("burst overflow", 32'(overflow), 32'(1));
        check("burst level full", 32'(fifo_level), 32'(DEPTH));
        tx_buf[0] = 8'($urandom);
        spi_xfer(1);
        check("full status", 32'(rx_buf[0]), 32'(exp_status(1, DEPTH)));
        check("full re-overflow", 32'(overflow), 32'(1));
        drain("burst");
        check("sticky overflow", 32'(overflow), 32'(1));
        tx_buf[0] = 8'($urandom);
        spi_xfer(1);
        exp_q.push_back(tx_buf[0]);
        check("ovf read status", 32'(rx_buf[0]), 32'(exp_status(1, 0)));
        check("ovf cleared", 32'(overflow), 32'(0));
        drain("ovf read");

        spi_partial(5, 8'hFF);
        check("partial level", 32'(fifo_level), 32'(0));
        check("partial busy", 32'(tx_busy), 32'(0));
        check("partial miso", 32'(miso), 32'(0));
        tx_buf[0] = 8'h3C;
        spi_xfer(1);
        exp_q.push_back(8'h3C);
        check("3c status", 32'(rx_buf[0]), 32'(exp_status(0, 0)));
        drain("3c");

        tx_buf[0] = 8'h07;
        spi_xfer(1);
        exp_q.push_back(8'h07);
        drain("07");

        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                tx_buf[i] = 8'($urandom);
                exp_q.push_back(tx_buf[i]);
            end
            spi_xfer(n);
            check("rand status", 32'(rx_buf[0]), 32'(exp_status(0, 0)));
            check("rand overflow", 32'(overflow), 32'(0));
            drain("rand");
        end

        tx_buf[0] = 8'h00;
        tx_buf[1] = 8'($urandom);
        spi_xfer(2);
        check("pre-reset busy", 32'(tx_busy), 32'(1));
        check("pre-reset level", 32'(fifo_level), 32'(1));
        check("pre-reset line low", 32'(uart_tx), 32'(0));
        mon_abort = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("mid-frame reset line", 32'(uart_tx), 32'(1));
        check("mid-frame reset busy", 32'(tx_busy), 32'(0));
        check("mid-frame reset level", 32'(fifo_level), 32'(0));
        reset = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        mon_abort = 1'b0;
        got_q.delete();
        drain("post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
